uart_tx_ctrl: RTL and testbench

UART transmit controller that sits between the TX `fifo_uart` buffer and the serial pin. It pops bytes from the FIFO when data is available and serializes each byte into an asynchronous frame: start bit, 5–8 data bits LSB first, optional parity, and 1 or 2 stop bits. Bit timing comes from the shared baud generator's oversampled tick. The block also owns line-break generation and reports frame completion to the UART status logic.

---
 rtl/uart_tx_ctrl_if.sv | 29 ++
 rtl/uart_tx_ctrl.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_ctrl_if.sv
// Signal bundle between the UART TX controller, its FIFO, the baud generator and the status logic.
// The controller uses the slave view; whatever drives config and FIFO data uses the master view.
interface uart_tx_ctrl_if;
   logic       baud_tick;
   logic       tx_en;
   logic [1:0] data_len;
   logic       parity_en;
   logic       parity_odd;
   logic       stop2;
   logic       break_req;
   logic       fifo_empty;
   logic [7:0] fifo_dout;
   logic       fifo_pop;
   logic       txd;
   logic       busy;
   logic       tx_done;

   modport master (
      output baud_tick, tx_en, data_len, parity_en, parity_odd, stop2, break_req,
             fifo_empty, fifo_dout,
      input  fifo_pop, txd, busy, tx_done
   );

   modport slave (
      input  baud_tick, tx_en, data_len, parity_en, parity_odd, stop2, break_req,
             fifo_empty, fifo_dout,
      output fifo_pop, txd, busy, tx_done
   );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: pops one byte per frame from the TX FIFO and serializes it as
// start, 5-8 data bits LSB first, optional parity and 1-2 stop bits; also drives line break.
module uart_tx_ctrl #(
   parameter int OVERSAMPLE = 16
) (
   input logic           clk,
   input logic           rst,
   uart_tx_ctrl_if.slave bus_io
);

   typedef enum logic [2:0] {IDLE, BREAK, POP, LOAD, START, DATA, PARITY, STOP} state_e;

   localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [CW-1:0] TICK_LAST = CW'(OVERSAMPLE - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] tick_q, tick_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic [1:0]    len_q, len_d;
   logic          par_en_q, par_en_d;
   logic          par_q, par_d;
   logic          stop2_q, stop2_d;
   logic          stop_cnt_q, stop_cnt_d;
   logic          txd_q, txd_d;
   logic          pop_q, pop_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          inBit;
   logic          bitEnd;
   logic [7:0]    dataMask;

   // State and output registers; reset drops the frame in flight and parks the line high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         tick_q     <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         len_q      <= '0;
         par_en_q   <= 1'b0;
         par_q      <= 1'b0;
         stop2_q    <= 1'b0;
         stop_cnt_q <= 1'b0;
         txd_q      <= 1'b1;
         pop_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_q     <= tick_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         len_q      <= len_d;
         par_en_q   <= par_en_d;
         par_q      <= par_d;
         stop2_q    <= stop2_d;
         stop_cnt_q <= stop_cnt_d;
         txd_q      <= txd_d;
         pop_q      <= pop_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   // Next-state logic. Outputs are computed from the next state so they line up with it once registered.
   always_comb begin
      state_d    = state_q;
      tick_d     = tick_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      len_d      = len_q;
      par_en_d   = par_en_q;
      par_d      = par_q;
      stop2_d    = stop2_q;
      stop_cnt_d = stop_cnt_q;
      dataMask   = 8'hFF >> (2'd3 - bus_io.data_len);
      inBit      = (state_q == START) || (state_q == DATA) || (state_q == PARITY) || (state_q == STOP);
      bitEnd     = inBit && bus_io.baud_tick && (tick_q == TICK_LAST);

      // Every bit transition happens on bitEnd, which also clears the counter, so each bit starts from zero.
      if (!inBit) begin
         tick_d = '0;
      end else if (bus_io.baud_tick) begin
         tick_d = bitEnd ? '0 : tick_q + CW'(1);
      end

      case (state_q)
         IDLE: begin
            if (bus_io.break_req) begin
               state_d = BREAK;
            end else if (bus_io.tx_en && !bus_io.fifo_empty) begin
               state_d = POP;
            end
         end
         BREAK: begin
            if (!bus_io.break_req) begin
               state_d = IDLE;
            end
         end
         POP: state_d = LOAD;
         LOAD: begin
            shift_d    = bus_io.fifo_dout;
            len_d      = bus_io.data_len;
            par_en_d   = bus_io.parity_en;
            stop2_d    = bus_io.stop2;
            par_d      = (^(bus_io.fifo_dout & dataMask)) ^ bus_io.parity_odd;
            bit_d      = '0;
            stop_cnt_d = 1'b0;
            state_d    = START;
         end
         START: begin
            if (bitEnd) begin
               state_d = DATA;
            end
         end
         DATA: begin
            // Index of the last data bit is 4 + len, i.e. {1, len}.
            if (bitEnd) begin
               shift_d = shift_q >> 1;
               bit_d   = bit_q + 3'd1;
               if (bit_q == {1'b1, len_q}) begin
                  state_d = par_en_q ? PARITY : STOP;
               end
            end
         end
         PARITY: begin
            if (bitEnd) begin
               state_d = STOP;
            end
         end
         STOP: begin
            if (bitEnd) begin
               if (stop2_q && !stop_cnt_q) begin
                  stop_cnt_d = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      pop_d  = (state_d == POP);
      busy_d = (state_d == POP) || (state_d == LOAD) || (state_d == START) ||
               (state_d == DATA) || (state_d == PARITY) || (state_d == STOP);
      done_d = (state_q == STOP) && (state_d == IDLE);
      case (state_d)
         BREAK:   txd_d = 1'b0;
         START:   txd_d = 1'b0;
         DATA:    txd_d = shift_d[0];
         PARITY:  txd_d = par_d;
         default: txd_d = 1'b1;
      endcase
   end

   assign bus_io.fifo_pop = pop_q;
   assign bus_io.txd      = txd_q;
   assign bus_io.busy     = busy_q;
   assign bus_io.tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: stimulus queues bytes plus hand-computed frames, a monitor
// decodes txd mid-bit and compares each frame against the expected queue.
module tb_uart_tx_ctrl;

   localparam int OS = 16;

   typedef struct {
      logic [11:0] bits;
      int          len;
      bit          gapChk;
      bit          skip;
   } frame_t;

   logic       clk;
   logic       rst;
   int         testsRun = 0;
   int         failures = 0;
   int         popCount = 0;
   int         doneCount = 0;
   int         cycleCount = 0;
   int         lastDoneCycle = 0;
   int         tickDiv = 1;
   bit         monBusy = 0;
   frame_t     expQ[$];
   logic [7:0] fifoQ[$];

   uart_tx_ctrl_if ifc();

   uart_tx_ctrl #(.OVERSAMPLE(OS)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycleCount++;

   // Baud tick every tickDiv clocks, changed away from the active edge.
   initial begin
      int tickCnt;
      tickCnt = 0;
      ifc.baud_tick = 1'b1;
      forever begin
         @(negedge clk);
         tickCnt++;
         ifc.baud_tick = ((tickCnt % tickDiv) == 0);
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] data, input logic [11:0] bits, input int len,
                                input bit gapChk, input bit skip);
      frame_t f;
      f.bits   = bits;
      f.len    = len;
      f.gapChk = gapChk;
      f.skip   = skip;
      expQ.push_back(f);
      fifoQ.push_back(data);
   endtask

   task automatic timeoutFail(input string name);
      testsRun++;
      failures++;
      $display("[TB] FAIL %s: wait expired", name);
   endtask

   task automatic waitIdle(input int maxCyc);
      int k;
      k = 0;
      while ((expQ.size() != 0 || monBusy || ifc.busy) && k < maxCyc) begin
         @(negedge clk);
         k++;
      end
      if (k >= maxCyc) timeoutFail("idle_timeout");
      repeat (4) @(negedge clk);
   endtask

   task automatic waitBusy(input int maxCyc);
      int k;
      k = 0;
      while (!ifc.busy && k < maxCyc) begin
         @(negedge clk);
         k++;
      end
      if (k >= maxCyc) timeoutFail("busy_timeout");
   endtask

   // FIFO model: data appears the cycle after a pop; empty flag updated just after each edge.
   initial begin
      bit popped;
      ifc.fifo_empty = 1'b1;
      ifc.fifo_dout  = 8'h00;
      forever begin
         @(posedge clk);
         popped = ifc.fifo_pop;
         #1;
         if (popped) begin
            popCount++;
            checkOutput("pop_nonempty", fifoQ.size() > 0, 1);
            if (fifoQ.size() > 0) ifc.fifo_dout = fifoQ.pop_front();
         end
         ifc.fifo_empty = (fifoQ.size() == 0);
      end
   end

   always @(negedge clk) begin
      if (ifc.tx_done) begin
         doneCount++;
         lastDoneCycle = cycleCount;
      end
   end

   // Monitor: a falling txd while busy marks a start bit; each bit is sampled at its midpoint.
   initial begin
      frame_t      item;
      logic [11:0] cap;
      logic        prevTxd;
      int          gap, bitClk, half, k;
      bit          ok;
      prevTxd = 1'b1;
      forever begin
         @(negedge clk);
         if (!rst && ifc.busy && !ifc.txd && prevTxd) begin
            gap = cycleCount - lastDoneCycle;
            if (expQ.size() == 0) begin
               timeoutFail("unexpected_frame");
            end else begin
               item    = expQ.pop_front();
               monBusy = 1;
               if (item.skip) begin
                  for (int w = 0; w < 4000 && ifc.busy; w++) @(negedge clk);
               end else begin
                  bitClk = OS * tickDiv;
                  half   = bitClk / 2;
                  if (item.gapChk) checkOutput("frame_gap", gap, 3);
                  cap = '0;
                  repeat (half) @(negedge clk);
                  for (int i = 0; i < item.len; i++) begin
                     if (i > 0) repeat (bitClk) @(negedge clk);
                     cap[i] = ifc.txd;
                  end
                  checkOutput("frame_bits", cap, item.bits);
                  for (k = 0; k < bitClk && !ifc.tx_done; k++) @(negedge clk);
                  ok = (k == half) || (tickDiv > 1 && k == half - 1);
                  checkOutput("tx_done_time", ok ? half : k, half);
                  checkOutput("busy_at_done", ifc.busy, 0);
               end
               monBusy = 0;
            end
         end
         prevTxd = ifc.txd;
      end
   end

   initial begin
      #2ms;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int basePop, baseDone, k;
      rst            = 1'b1;
      ifc.tx_en      = 1'b0;
      ifc.data_len   = 2'b11;
      ifc.parity_en  = 1'b0;
      ifc.parity_odd = 1'b0;
      ifc.stop2      = 1'b0;
      ifc.break_req  = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_txd", ifc.txd, 1);
      checkOutput("reset_busy", ifc.busy, 0);
      checkOutput("reset_pop", ifc.fifo_pop, 0);
      checkOutput("reset_done", ifc.tx_done, 0);
      rst = 1'b0;
      ifc.tx_en = 1'b1;
      @(negedge clk);

      // 8N1 0xA5 with latency checks.
      basePop = popCount;
      baseDone = doneCount;
      applyStimulus(8'hA5, 12'b1101001010, 10, 0, 0);
      for (k = 0; k < 10 && ifc.fifo_empty; k++) @(negedge clk);
      @(negedge clk);
      checkOutput("pop_latency", ifc.fifo_pop, 1);
      repeat (2) @(negedge clk);
      checkOutput("start_latency", ifc.txd, 0);
      waitIdle(400);
      checkOutput("pops_8n1", popCount - basePop, 1);
      checkOutput("dones_8n1", doneCount - baseDone, 1);

      // 7E1 0x55, ticks every other clock.
      tickDiv = 2;
      ifc.data_len  = 2'b10;
      ifc.parity_en = 1'b1;
      applyStimulus(8'h55, 12'b1010101010, 10, 0, 0);
      waitIdle(800);
      tickDiv = 1;

      // 5O2 0x1F; stop2 cleared during DATA must not shorten the frame.
      ifc.data_len   = 2'b00;
      ifc.parity_odd = 1'b1;
      ifc.stop2      = 1'b1;
      applyStimulus(8'h1F, 12'b110111110, 9, 0, 0);
      waitBusy(20);
      repeat (30) @(negedge clk);
      ifc.stop2 = 1'b0;
      waitIdle(400);

      // Three queued 8N1 bytes back to back.
      ifc.data_len   = 2'b11;
      ifc.parity_en  = 1'b0;
      ifc.parity_odd = 1'b0;
      basePop = popCount;
      baseDone = doneCount;
      applyStimulus(8'h01, 12'b1000000010, 10, 0, 0);
      applyStimulus(8'h80, 12'b1100000000, 10, 1, 0);
      applyStimulus(8'h3C, 12'b1001111000, 10, 1, 0);
      waitIdle(1000);
      checkOutput("pops_burst", popCount - basePop, 3);
      checkOutput("dones_burst", doneCount - baseDone, 3);

      // tx_en low holds a waiting byte.
      ifc.tx_en = 1'b0;
      basePop = popCount;
      applyStimulus(8'h81, 12'b1100000010, 10, 0, 0);
      repeat (30) @(negedge clk);
      checkOutput("tx_en_no_pop", popCount - basePop, 0);
      checkOutput("tx_en_not_busy", ifc.busy, 0);
      ifc.tx_en = 1'b1;
      waitIdle(400);

      // Break raised mid-frame, with a second byte waiting.
      basePop = popCount;
      applyStimulus(8'h0F, 12'b1000011110, 10, 0, 0);
      waitBusy(20);
      repeat (40) @(negedge clk);
      ifc.break_req = 1'b1;
      applyStimulus(8'hF0, 12'b1111100000, 10, 0, 0);
      for (k = 0; k < 400 && !ifc.tx_done; k++) @(negedge clk);
      if (k >= 400) timeoutFail("break_done_timeout");
      repeat (6) @(negedge clk);
      checkOutput("break_low", ifc.txd, 0);
      checkOutput("break_no_pop", popCount - basePop, 1);
      checkOutput("break_not_busy", ifc.busy, 0);
      repeat (20) @(negedge clk);
      ifc.break_req = 1'b0;
      waitIdle(400);
      checkOutput("break_pops", popCount - basePop, 2);

      // Asynchronous reset during DATA.
      applyStimulus(8'hC3, 12'b0, 10, 0, 1);
      waitBusy(20);
      repeat (40) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("rst_txd", ifc.txd, 1);
      checkOutput("rst_busy", ifc.busy, 0);
      checkOutput("rst_pop", ifc.fifo_pop, 0);
      basePop = popCount;
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      checkOutput("rst_no_pop", popCount - basePop, 0);
      checkOutput("rst_idle", ifc.busy, 0);
      applyStimulus(8'h5A, 12'b1010110100, 10, 0, 0);
      waitIdle(400);
      checkOutput("rst_next_pop", popCount - basePop, 1);

      $display("[TB] %0d tests run, %0d failed", testsRun, failures);
      $finish;
   end

endmodule
